// File: rtl/knight_uart_pkg.sv
// -----------------------------------------------------------------------------
// knight_uart_pkg
// Shared types and constants for the Knight-side RemoteComm UART link.
//   asm_state_t         : two-byte command assembly state (HIGH byte / LOW byte)
//   POS_ACK             : positive acknowledge response byte
//   BAUD_CYCLES_DEFAULT : clocks per UART bit, 19200 baud at 50 MHz
// -----------------------------------------------------------------------------
package knight_uart_pkg;

    typedef enum logic {
        HIGH = 1'b0,
        LOW  = 1'b1
    } asm_state_t;

    localparam logic [7:0] POS_ACK             = 8'hA5;
    localparam int         BAUD_CYCLES_DEFAULT = 2604;

endpackage

// File: rtl/uart_trcv.sv
// -----------------------------------------------------------------------------
// uart_trcv
// Full-duplex 8N1 UART transceiver. RX and TX are completely independent.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   RX           : serial input, idle high (synchronised internally)
//   TX           : serial output, idle high
//   rx_data      : last received byte
//   rx_rdy       : level, a received byte is waiting; cleared by clr_rx_rdy
//   clr_rx_rdy   : pulse, consumer has taken rx_data
//   trmt         : pulse, start sending tx_data (ignored while busy)
//   tx_data      : byte to send, sampled on the accepted trmt cycle
//   tx_done      : level, set at end of stop bit, cleared on next accepted trmt
// -----------------------------------------------------------------------------
module uart_trcv
    import knight_uart_pkg::*;
#(
    parameter int BAUD_CYCLES = BAUD_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);

    localparam int               CNT_W     = $clog2(BAUD_CYCLES);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_CYCLES / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ---------------------------------------------------------------- RX ----
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic             r_rx_busy;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [3:0]       r_rx_bits;
    logic [7:0]       r_rx_shift;
    logic             r_rx_rdy;
    logic             w_rx_fall;
    logic             w_rx_tick;

    // Synchroniser flops preset to the idle level so reset release never
    // looks like a start bit.
    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge values of the others; = here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;
    assign w_rx_tick = r_rx_busy && (r_rx_cnt == '0);

    // First sample lands half a bit after the start edge, the rest one full
    // bit apart: sample 0 is the start bit, 1..8 data (LSB first), 9 stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
        end else if (!r_rx_busy) begin
            if (w_rx_fall) begin
                r_rx_busy <= 1'b1;
                r_rx_cnt  <= BAUD_HALF;
                r_rx_bits <= '0;
            end
        end else if (w_rx_tick) begin
            if ((r_rx_bits != 4'd0) && (r_rx_bits != 4'd9)) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
            r_rx_cnt  <= BAUD_LAST;
            r_rx_bits <= r_rx_bits + 4'd1;
            if (r_rx_bits == 4'd9) begin
                r_rx_busy <= 1'b0;
            end
        end else begin
            r_rx_cnt <= r_rx_cnt - CNT_ONE;
        end
    end

    // Registered on the stop-bit sample edge; completion beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_rdy <= 1'b0;
        end else if (w_rx_tick && (r_rx_bits == 4'd9)) begin
            r_rx_rdy <= 1'b1;
        end else if (clr_rx_rdy || (w_rx_fall && !r_rx_busy)) begin
            r_rx_rdy <= 1'b0;
        end
    end

    assign rx_data = r_rx_shift;
    assign rx_rdy  = r_rx_rdy;

    // ---------------------------------------------------------------- TX ----
    logic [9:0]       r_tx_shift;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [3:0]       r_tx_bits;
    logic             r_tx_busy;
    logic             r_tx_done;

    // The frame register idles at all ones, so TX is a glitch-free flop
    // output that drops on the edge that accepts trmt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else if (!r_tx_busy) begin
            if (trmt) begin
                r_tx_shift <= {1'b1, tx_data, 1'b0};
                r_tx_cnt   <= BAUD_LAST;
                r_tx_bits  <= '0;
                r_tx_busy  <= 1'b1;
                r_tx_done  <= 1'b0;
            end
        end else if (r_tx_cnt == '0) begin
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            r_tx_cnt   <= BAUD_LAST;
            r_tx_bits  <= r_tx_bits + 4'd1;
            if (r_tx_bits == 4'd9) begin
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt - CNT_ONE;
        end
    end

    assign TX      = r_tx_shift[0];
    assign tx_done = r_tx_done;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// -----------------------------------------------------------------------------
// cmd_uart_wrapper
// Knight-side end of the RemoteComm link. Assembles two received bytes
// (high first) into a 16-bit command and serialises response bytes back.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   RX, TX      : serial in / out, both idle high
//   cmd         : assembled {high_byte, low_byte}, held until next command
//   cmd_rdy     : level, cmd holds a complete command
//   clr_cmd_rdy : pulse, clears cmd_rdy
//   trmt, resp  : pulse + byte to transmit (resp sampled on accepted trmt)
//   tx_done     : level, last response fully sent
// -----------------------------------------------------------------------------
module cmd_uart_wrapper
    import knight_uart_pkg::*;
#(
    parameter int          BAUD_CYCLES    = BAUD_CYCLES_DEFAULT,
    parameter logic [21:0] TIMEOUT_CYCLES = 22'd2_600_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    logic [7:0]  w_rx_data;
    logic        w_rx_rdy;
    logic        w_clr_rx_rdy;

    asm_state_t  r_state;
    asm_state_t  w_state_nxt;
    logic        w_hi_accept;
    logic        w_lo_accept;
    logic        w_tmo_expire;
    logic        w_timeout;

    logic [7:0]  r_high_byte;
    logic [21:0] r_tmo_cnt;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;

    uart_trcv #(
        .BAUD_CYCLES(BAUD_CYCLES)
    ) u_trcv (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_data    (w_rx_data),
        .rx_rdy     (w_rx_rdy),
        .clr_rx_rdy (w_clr_rx_rdy),
        .trmt       (trmt),
        .tx_data    (resp),
        .tx_done    (tx_done)
    );

    assign w_timeout = (r_tmo_cnt == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HIGH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A byte arriving on the timeout cycle is still taken as the low byte.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and infers a latch.
        w_state_nxt  = r_state;
        w_clr_rx_rdy = 1'b0;
        w_hi_accept  = 1'b0;
        w_lo_accept  = 1'b0;
        w_tmo_expire = 1'b0;
        case (r_state)
            HIGH: begin
                if (w_rx_rdy) begin
                    w_hi_accept  = 1'b1;
                    w_clr_rx_rdy = 1'b1;
                    w_state_nxt  = LOW;
                end
            end
            LOW: begin
                if (w_rx_rdy) begin
                    w_lo_accept  = 1'b1;
                    w_clr_rx_rdy = 1'b1;
                    w_state_nxt  = HIGH;
                end else if (w_timeout) begin
                    w_tmo_expire = 1'b1;
                    w_state_nxt  = HIGH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_byte <= '0;
            r_tmo_cnt   <= '0;
        end else if (w_hi_accept) begin
            r_high_byte <= w_rx_data;
            r_tmo_cnt   <= '0;
        end else if (w_tmo_expire) begin
            r_high_byte <= '0;
            r_tmo_cnt   <= '0;
        end else if (r_state == LOW) begin
            r_tmo_cnt <= r_tmo_cnt + 22'd1;
        end
    end

    // cmd only ever moves to a complete command; a completion beats a
    // simultaneous clear of cmd_rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
        end else begin
            if (w_lo_accept) begin
                r_cmd <= {r_high_byte, w_rx_data};
            end
            if (w_lo_accept) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || w_hi_accept) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

endmodule

// File: doc/cmd_uart_wrapper.md
Name: cmd_uart_wrapper

Overview:
- Knight-side end of the RemoteComm link.
- Receives two UART bytes (high byte first) and assembles them into a 16-bit command for cmd_proc, flagged by cmd_rdy.
- Serializes the 8-bit response byte (e.g. positive ack 8'hA5) back to RemoteComm.
- Sits inside KnightsTour between the RX/TX pins and the command processor.

Parameters:
- BAUD_CYCLES, 2604, clocks per UART bit (19200 baud at 50 MHz); minimum 16.
- TIMEOUT_CYCLES, 22'd2_600_000, max clocks from the high-byte stop bit to the low-byte stop bit before the partial command is discarded.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RX  in  1  serial in from RemoteComm; idle high; double-flopped internally, flops preset to 1.
- TX  out  1  serial out to RemoteComm; idle high.
- cmd  out  16  assembled command {high_byte, low_byte}.
- cmd_rdy  out  1  level; a complete command is valid on cmd.
- clr_cmd_rdy  in  1  pulse from cmd_proc that clears cmd_rdy.
- trmt  in  1  pulse to start transmitting resp.
- resp  in  8  response byte, sampled on the trmt cycle.
- tx_done  out  1  level; set when the stop bit completes; cleared on the next accepted trmt.

Behaviour:
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0. The FSM enters HIGH, and all counters and shift registers clear.
- Reset mid-frame: the frame is abandoned. There is no partial cmd and no spurious rx_rdy after release.
- RX framing (in uart_trcv):
  - Start bit detected on the synchronized falling edge.
  - Each bit is sampled at BAUD_CYCLES/2 into the bit, LSB first, 8 data bits.
  - rx_rdy asserts one clk after the stop-bit sample.
  - Stop bit value is not checked.
- TX framing: start bit (0), 8 data bits LSB first, stop bit (1); each bit lasts exactly BAUD_CYCLES clocks.
- TX handshake:
  - trmt is accepted only when the transmitter is idle; the bit after tx_done rises counts as idle.
  - trmt while busy is ignored; resp is not re-sampled and tx_done is unaffected.
  - TX falls on the clk after trmt.
  - tx_done rises at the end of the stop bit, 10*BAUD_CYCLES clocks after TX falls.
- Assembly FSM states:
  - HIGH:
    - Waits for rx_rdy.
    - On rx_rdy: latch rx_data into high_byte, pulse clr_rx_rdy, clear cmd_rdy, load the timeout counter, go to LOW.
  - LOW:
    - On rx_rdy: cmd <= {high_byte, rx_data}, cmd_rdy <= 1 on the next clk edge, pulse clr_rx_rdy, go to HIGH.
    - If the timeout counter reaches TIMEOUT_CYCLES first: discard high_byte, go to HIGH, leave cmd and cmd_rdy untouched.
- cmd holds its value until the next complete command; it does not change on timeout or on a high byte alone.
- cmd_rdy clears on clr_cmd_rdy or on acceptance of a new high byte.
- Simultaneous events:
  - clr_cmd_rdy in the same cycle as a low-byte completion: set wins, cmd_rdy=1.
  - rx_rdy on the exact timeout cycle: the byte is accepted as the low byte; the timeout loses.
- RX and TX operate full-duplex and independently.

Decomposition:
- Package knight_uart_pkg:
  - typedef enum logic {HIGH, LOW} asm_state_t.
  - localparam POS_ACK = 8'hA5.
  - localparam BAUD_CYCLES_DEFAULT = 2604.
- Sub-module uart_trcv, parameterized by BAUD_CYCLES: contains the RX sampler and TX shifter, and exposes rx_data, rx_rdy, clr_rx_rdy, trmt, tx_data, tx_done.
- The wrapper holds only the assembly FSM, the timeout counter and the cmd/cmd_rdy registers.

Test Plan:
- Drive 8'h43 then 8'hF2 via RemoteComm with cmd=16'h43F2 -> cmd=16'h43F2 and cmd_rdy=1 within 2 clk of the second stop bit; cmd_rdy holds until clr_cmd_rdy, then reads 0 next clk.
- Send 16'h5001 while cmd_rdy is still set from 16'h43F2 -> cmd_rdy drops at the high-byte acceptance, rises with cmd=16'h5001; no intermediate cmd value appears.
- Send only byte 8'h43, then wait TIMEOUT_CYCLES+10 -> FSM back in HIGH and cmd_rdy stays 0; then send 8'h29 then 8'h00 -> cmd=16'h2900, confirming the stale byte was discarded.
- trmt with resp=8'hA5 -> TX waveform 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each bit BAUD_CYCLES wide; tx_done rises; RemoteComm resp_rdy with resp=8'hA5.
- Second trmt with resp=8'h5A mid-transmission -> ignored, 8'hA5 still received intact; a trmt after tx_done clears tx_done on the next clk and 8'h5A is sent.
- Assert rst_n=0 mid-way through a low byte -> TX=1, cmd=0, cmd_rdy=0 immediately; after release, a full 16'h43F2 is received correctly.
